// File: rtl/fdc_seek_pkg.sv
// Shared types and step-rate timing for the fdc1772 head/spindle sequencer.
// Rate codes map to 6/12/2/3 ms step intervals.
package fdc_seek_pkg;

  typedef enum logic [3:0] {
    IDLE,
    SPINUP,
    DECIDE,
    PULSE,
    STEP_WAIT,
    SETTLE,
    VERIFY,
    DONE,
    MOTOR_OFF_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OP_RESTORE,
    OP_SEEK,
    OP_STEP_IN,
    OP_STEP_OUT
  } op_t;

  localparam logic [6:0] MAX_TRACK = 7'd84;
  localparam int TMR_W = 17;

  function automatic logic [TMR_W-1:0] rate_clks(
    input int         sys_clk,
    input logic [1:0] rate
  );
    int ms;
    case (rate)
      2'd0:    ms = 6;
      2'd1:    ms = 12;
      2'd2:    ms = 2;
      default: ms = 3;
    endcase
    return TMR_W'(ms * sys_clk / 1000);
  endfunction

endpackage

// File: rtl/fdc_index_edge.sv
// Index pulse synchronizer, rising-edge detector and reloadable
// event counter; expire marks the edge that completes the count.
module fdc_index_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idx,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic       sync_q;
  logic       edge_q;
  logic [7:0] cnt_q;
  logic       evt;

  assign evt    = sync_q & ~edge_q;
  assign expire = evt & (cnt_q == 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      edge_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= idx;
      edge_q <= sync_q;
      if (load)
        cnt_q <= load_val;
      else if (evt && cnt_q != '0)
        cnt_q <= cnt_q - 8'd1;
    end
  end

endmodule

// File: rtl/fdc_seek_ctrl.sv
// Head-positioning and spindle sequencer for the fdc1772 virtual drive:
// spin-up, stepping with real step-rate timing, verify, idle motor-off.
module fdc_seek_ctrl
  import fdc_seek_pkg::*;
#(
  parameter int SYS_CLK         = 8000000,
  parameter int STEP_PULSE_CLKS = 32,
  parameter int SPINUP_IDX      = 6,
  parameter int IDLE_IDX        = 10,
  parameter int RESTORE_MAX     = 255,
  parameter int VERIFY_IDX      = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [6:0] cmd_track,
  input  logic [1:0] cmd_rate,
  input  logic       cmd_verify,
  input  logic       drv_ready,
  input  logic       drv_index,
  input  logic [6:0] drv_track,
  output logic       motor_on,
  output logic       step_in,
  output logic       step_out,
  output logic [6:0] track_reg,
  output logic       done,
  output logic       seek_err
);

  localparam logic [TMR_W-1:0] RC0 = rate_clks(SYS_CLK, 2'd0);
  localparam logic [TMR_W-1:0] RC1 = rate_clks(SYS_CLK, 2'd1);
  localparam logic [TMR_W-1:0] RC2 = rate_clks(SYS_CLK, 2'd2);
  localparam logic [TMR_W-1:0] RC3 = rate_clks(SYS_CLK, 2'd3);
  localparam logic [TMR_W-1:0] PULSE_END =
    TMR_W'(STEP_PULSE_CLKS - 1);

  state_t           state_q, state_d;
  op_t              op_q;
  logic [6:0]       tgt_q;
  logic [1:0]       rate_q;
  logic             vfy_q;
  logic             dir_in_q;
  logic [6:0]       track_q;
  logic             motor_q;
  logic             err_q;
  logic [7:0]       step_cnt_q;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] wait_clks;
  logic [TMR_W-1:0] wait_end;

  logic       accept;
  logic       at_goal;
  logic       go_in;
  logic       lim_hit;
  logic       multi;
  logic       trk_match;
  logic       idx_load;
  logic [7:0] idx_load_val;
  logic       idx_exp;

  assign cmd_ready = (state_q == IDLE) ||
                     (state_q == MOTOR_OFF_WAIT);
  assign accept    = cmd_valid && cmd_ready;
  assign multi     = (op_q == OP_SEEK) || (op_q == OP_RESTORE);
  assign trk_match = drv_track == track_q;

  // Wait ends one cycle early: the DECIDE cycle completes the interval
  always_comb begin
    wait_clks = RC3;
    case (rate_q)
      2'd0:    wait_clks = RC0;
      2'd1:    wait_clks = RC1;
      2'd2:    wait_clks = RC2;
      default: wait_clks = RC3;
    endcase
    wait_end = wait_clks - TMR_W'(2);
  end

  always_comb begin
    at_goal = 1'b0;
    go_in   = 1'b0;
    case (op_q)
      OP_RESTORE: begin
        at_goal = drv_track == '0;
        go_in   = 1'b1;
      end
      OP_SEEK: begin
        at_goal = tgt_q == track_q;
        go_in   = tgt_q < track_q;
      end
      OP_STEP_IN: begin
        at_goal = track_q == '0;
        go_in   = 1'b1;
      end
      default: at_goal = track_q == MAX_TRACK;
    endcase
  end

  assign lim_hit = (op_q == OP_RESTORE) && !at_goal &&
                   (step_cnt_q >= 8'(RESTORE_MAX));

  fdc_index_edge u_idx (
    .clk      (clk),
    .rst_n    (reset_n),
    .idx      (drv_index),
    .load     (idx_load),
    .load_val (idx_load_val),
    .expire   (idx_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (accept) state_d = motor_q ? DECIDE : SPINUP;
      SPINUP:
        if (idx_exp) state_d = DECIDE;
      DECIDE:
        if (lim_hit)      state_d = DONE;
        else if (at_goal) state_d = SETTLE;
        else              state_d = PULSE;
      PULSE:
        if (tmr_q == PULSE_END) state_d = STEP_WAIT;
      STEP_WAIT:
        if (tmr_q >= wait_end)
          state_d = multi ? DECIDE : SETTLE;
      SETTLE:
        if (drv_ready) state_d = vfy_q ? VERIFY : DONE;
      VERIFY:
        if (trk_match || idx_exp) state_d = DONE;
      DONE:
        state_d = MOTOR_OFF_WAIT;
      MOTOR_OFF_WAIT:
        if (accept)       state_d = DECIDE;
        else if (idx_exp) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    step_in      = (state_q == PULSE) && dir_in_q;
    step_out     = (state_q == PULSE) && !dir_in_q;
    done         = state_q == DONE;
    idx_load     = 1'b0;
    idx_load_val = '0;
    unique case (1'b1)
      accept: begin
        idx_load     = 1'b1;
        idx_load_val = motor_q ? 8'(IDLE_IDX) : 8'(SPINUP_IDX);
      end
      (state_q == SETTLE) && drv_ready && vfy_q: begin
        idx_load     = 1'b1;
        idx_load_val = 8'(VERIFY_IDX);
      end
      state_q == DONE: begin
        idx_load     = 1'b1;
        idx_load_val = 8'(IDLE_IDX);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= OP_RESTORE;
      tgt_q      <= '0;
      rate_q     <= '0;
      vfy_q      <= 1'b0;
      dir_in_q   <= 1'b0;
      track_q    <= '0;
      motor_q    <= 1'b0;
      err_q      <= 1'b0;
      step_cnt_q <= '0;
      tmr_q      <= '0;
    end else begin
      tmr_q <= tmr_q + TMR_W'(1);
      if (accept) begin
        op_q       <= op_t'(cmd_op);
        tgt_q      <= cmd_track;
        rate_q     <= cmd_rate;
        vfy_q      <= cmd_verify;
        err_q      <= 1'b0;
        step_cnt_q <= '0;
        motor_q    <= 1'b1;
      end else if (state_q == MOTOR_OFF_WAIT && idx_exp) begin
        motor_q <= 1'b0;
      end
      if (state_q == DECIDE) begin
        tmr_q <= '0;
        if (lim_hit) begin
          err_q <= 1'b1;
        end else if (at_goal) begin
          if (op_q == OP_RESTORE) track_q <= '0;
        end else begin
          dir_in_q <= go_in;
          if (step_cnt_q != 8'hff)
            step_cnt_q <= step_cnt_q + 8'd1;
          if (op_q != OP_RESTORE)
            track_q <= go_in ? track_q - 7'd1 : track_q + 7'd1;
        end
      end
      if (state_q == VERIFY && !trk_match && idx_exp)
        err_q <= 1'b1;
    end
  end

  assign motor_on  = motor_q;
  assign track_reg = track_q;
  assign seek_err  = err_q;

endmodule

// File: tb/tb_fdc_seek_ctrl.sv
// Scoreboard bench for fdc_seek_ctrl with a stepping drive model
// and a free-running index; clock scaled so ms waits stay short.
module tb_fdc_seek_ctrl;

  localparam int SYSC    = 50000;
  localparam int SPC     = 8;
  localparam int IDX_PER = 200;
  localparam int G0      = 6 * SYSC / 1000;
  localparam int G2      = 2 * SYSC / 1000;

  typedef struct {
    logic [6:0] trk;
    logic       err;
    int         pulses;
    int         gap;
    int         spin;
    int         lat;
    logic       out;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [6:0] cmd_track = '0;
  logic [1:0] cmd_rate = '0;
  logic       cmd_verify = 1'b0;
  logic       drv_ready = 1'b1;
  logic       drv_index;
  logic [6:0] drv_track;
  logic       motor_on;
  logic       step_in;
  logic       step_out;
  logic [6:0] track_reg;
  logic       done;
  logic       seek_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   idx_ph = 100;
  int   dtrk = 0;
  int   preset = -1;
  logic force_en = 1'b0;
  logic [6:0] force_val = '0;
  logic psi = 1'b0;
  logic pso = 1'b0;
  exp_t q[$];

  fdc_seek_ctrl #(
    .SYS_CLK         (SYSC),
    .STEP_PULSE_CLKS (SPC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_track  (cmd_track),
    .cmd_rate   (cmd_rate),
    .cmd_verify (cmd_verify),
    .drv_ready  (drv_ready),
    .drv_index  (drv_index),
    .drv_track  (drv_track),
    .motor_on   (motor_on),
    .step_in    (step_in),
    .step_out   (step_out),
    .track_reg  (track_reg),
    .done       (done),
    .seek_err   (seek_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    idx_ph <= (idx_ph == IDX_PER - 1) ? 0 : idx_ph + 1;
  assign drv_index = idx_ph < 10;

  // Drive model: track follows step pulse rising edges
  always @(posedge clk) begin
    psi <= step_in;
    pso <= step_out;
    if (preset >= 0)
      dtrk <= preset;
    else if (step_in && !psi && dtrk > 0)
      dtrk <= dtrk - 1;
    else if (step_out && !pso && dtrk < 84)
      dtrk <= dtrk + 1;
  end
  assign drv_track = force_en ? force_val : 7'(dtrk);

  task automatic chk(input string nm, input int act,
                     input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input int trk, input int err,
                              input int pulses, input int gap,
                              input int spin, input int lat,
                              input int out);
    exp_t e;
    e.trk    = 7'(trk);
    e.err    = 1'(err);
    e.pulses = pulses;
    e.gap    = gap;
    e.spin   = spin;
    e.lat    = lat;
    e.out    = 1'(out);
    return e;
  endfunction

  initial begin : mon
    logic pidx, ps, po;
    int   acc_cyc, last_cyc, npul, idx_seen;
    exp_t e;
    pidx = 1'b0; ps = 1'b0; po = 1'b0;
    acc_cyc = 0; last_cyc = 0; npul = 0; idx_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        npul = 0; ps = 1'b0; po = 1'b0; pidx = drv_index;
        continue;
      end
      if (drv_index && !pidx) idx_seen++;
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc; idx_seen = 0; npul = 0;
      end
      if (step_in && step_out) chk("step_excl", 1, 0);
      if ((step_in && !ps) || (step_out && !po)) begin
        if (q.size() == 0) begin
          chk("pulse_no_cmd", 1, 0);
        end else begin
          chk("step_dir", step_out, q[0].out);
          if (npul == 0) begin
            if (q[0].spin >= 0)
              chk("spinup_idx", idx_seen, q[0].spin);
            if (q[0].lat >= 0)
              chk("start_lat", cyc - acc_cyc, q[0].lat);
          end else if (q[0].gap > 0) begin
            chk("step_gap", cyc - last_cyc, q[0].gap);
          end
          last_cyc = cyc;
          npul++;
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("done_no_cmd", 1, 0);
        end else begin
          e = q.pop_front();
          chk("track_reg", track_reg, e.trk);
          chk("seek_err", seek_err, e.err);
          chk("pulses", npul, e.pulses);
        end
        npul = 0;
        done_cnt++;
      end
      pidx = drv_index; ps = step_in; po = step_out;
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [6:0] trk,
                       input logic [1:0] rate,
                       input logic vfy, input exp_t e);
    cmd_op = op; cmd_track = trk;
    cmd_rate = rate; cmd_verify = vfy;
    cmd_valid = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int d0;
    int i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < lim) begin
      @(posedge clk);
      i++;
    end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * IDX_PER && idx_ph != p; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    int d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_motor", motor_on, 0);
    chk("rst_step_in", step_in, 0);
    chk("rst_step_out", step_out, 0);
    chk("rst_track", track_reg, 0);
    chk("rst_done", done, 0);
    chk("rst_err", seek_err, 0);
    chk("rst_ready", cmd_ready, 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Seek 10 from a stopped motor
    wait_phase(100);
    issue(2'd1, 7'd10, 2'd2, 1'b0, mk(10, 0, 10, G2, 6, -1, 1));
    repeat (4) @(posedge clk);
    #1;
    chk("motor_start", motor_on, 1);
    chk("busy", cmd_ready, 0);
    wait_done(5000);

    // Restore from drive track 5 with verify, ready held off
    drv_ready = 1'b0;
    preset = 5;
    issue(2'd0, 7'd0, 2'd2, 1'b1, mk(0, 0, 5, G2, -1, 2, 0));
    preset = -1;
    d0 = done_cnt;
    repeat (800) @(posedge clk);
    #1;
    chk("settle_hold", done_cnt, d0);
    drv_ready = 1'b1;
    wait_done(500);

    // Restore that never finds track 0
    force_en = 1'b1;
    force_val = 7'd3;
    issue(2'd0, 7'd0, 2'd2, 1'b0, mk(0, 1, 255, G2, -1, 2, 0));
    wait_done(30000);
    force_en = 1'b0;

    // Boundary single steps
    issue(2'd2, 7'd0, 2'd2, 1'b0, mk(0, 0, 0, 0, -1, -1, 0));
    wait_done(200);
    issue(2'd1, 7'd84, 2'd2, 1'b0, mk(84, 0, 84, G2, -1, 2, 1));
    wait_done(10000);
    issue(2'd3, 7'd0, 2'd2, 1'b0, mk(84, 0, 0, 0, -1, -1, 1));
    wait_done(200);
    issue(2'd2, 7'd0, 2'd3, 1'b0, mk(83, 0, 1, 0, -1, 2, 0));
    wait_done(500);
    issue(2'd3, 7'd0, 2'd3, 1'b0, mk(84, 0, 1, 0, -1, 2, 1));
    wait_done(500);

    // Verify mismatch by one track
    force_en = 1'b1;
    force_val = 7'd81;
    issue(2'd1, 7'd80, 2'd0, 1'b1, mk(80, 1, 4, G0, -1, 2, 0));
    wait_done(4000);
    force_en = 1'b0;

    // Idle timeout
    wait_phase(100);
    issue(2'd2, 7'd0, 2'd3, 1'b0, mk(79, 0, 1, 0, -1, 2, 0));
    wait_done(500);
    repeat (9) @(posedge drv_index);
    wait_phase(100);
    chk("motor_idle9", motor_on, 1);
    chk("ready_mow", cmd_ready, 1);
    @(posedge drv_index);
    repeat (5) @(posedge clk);
    #1;
    chk("motor_off", motor_on, 0);

    // Command at idle index 9 skips spin-up
    wait_phase(100);
    issue(2'd3, 7'd0, 2'd3, 1'b0, mk(80, 0, 1, 0, 6, -1, 1));
    wait_done(2000);
    repeat (9) @(posedge drv_index);
    wait_phase(100);
    chk("motor_hold", motor_on, 1);
    issue(2'd1, 7'd82, 2'd2, 1'b0, mk(82, 0, 2, G2, -1, 2, 1));
    wait_done(500);
    chk("queue_empty", q.size(), 0);

    // Reset in the middle of a step pulse
    issue(2'd1, 7'd84, 2'd2, 1'b0, mk(84, 0, 2, G2, -1, 2, 1));
    for (int i = 0; i < 20 && !step_out; i++) begin
      @(posedge clk); #1;
    end
    chk("pulse_seen", step_out, 1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_step_out", step_out, 0);
    chk("mid_rst_step_in", step_in, 0);
    chk("mid_rst_motor", motor_on, 0);
    chk("mid_rst_track", track_reg, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_err", seek_err, 0);
    q.delete();
    repeat (2) @(posedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
